// File: rtl/pool_window_if.sv
// Upstream sample bus and downstream result bus for the pooling stage.
// The pooling stage sits on the slave side of this interface.
interface pool_window_if #(
    parameter int NUM_WIDTH = 16,
    parameter int NUM_CHAN  = 4
);
    logic [NUM_CHAN*NUM_WIDTH-1:0] up_data;
    logic                          up_valid;
    logic [NUM_CHAN*NUM_WIDTH-1:0] dn_data;
    logic                          dn_valid;

    modport master (
        output up_data,
        output up_valid,
        input  dn_data,
        input  dn_valid
    );

    modport slave (
        input  up_data,
        input  up_valid,
        output dn_data,
        output dn_valid
    );
endinterface

// File: rtl/pool_window.sv
// Multi-channel pooling stage: folds each window of 2^WIN_LOG2 valid samples
// per channel into a signed maximum or a floored signed average.
module pool_window #(
    parameter int NUM_WIDTH = 16,
    parameter int NUM_CHAN  = 4,
    parameter int WIN_LOG2  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          cfg_mode,
    pool_window_if.slave  bus
);
    localparam int DW = NUM_CHAN * NUM_WIDTH;
    localparam int AW = NUM_WIDTH + WIN_LOG2;
    localparam int CW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << WIN_LOG2) - 1);

    logic [DW-1:0]        s1_data;
    logic                 s1_valid;
    logic                 s1_restart;
    logic                 s1_mode;

    logic [CW-1:0]        count;
    logic [CW-1:0]        eff_count;
    logic                 pending;
    logic                 mode_q;
    logic                 s2_done;
    logic                 first;
    logic                 last;
    logic                 eff_mode;

    logic signed [AW-1:0] acc      [NUM_CHAN];
    logic signed [AW-1:0] acc_next [NUM_CHAN];
    logic signed [AW-1:0] sample;
    logic signed [AW-1:0] shifted;
    logic [DW-1:0]        result;

    // A restart (fresh or still pending) makes the current sample count 0.
    always_comb begin
        eff_count = (s1_restart || pending) ? '0 : count;
        first     = (eff_count == '0);
        last      = (eff_count == LAST_CNT);
        eff_mode  = first ? s1_mode : mode_q;
        sample    = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            acc_next[c] = acc[c];
            sample      = AW'($signed(s1_data[c*NUM_WIDTH +: NUM_WIDTH]));
            if (first) begin
                acc_next[c] = sample;
            end else if (eff_mode) begin
                acc_next[c] = acc[c] + sample;
            end else if (sample > acc[c]) begin
                acc_next[c] = sample;
            end
        end
    end

    always_comb begin
        result  = '0;
        shifted = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            shifted = acc[c] >>> WIN_LOG2;
            result[c*NUM_WIDTH +: NUM_WIDTH] = mode_q ? shifted[NUM_WIDTH-1:0]
                                                      : acc[c][NUM_WIDTH-1:0];
        end
    end

    // S3 reads acc/mode_q before S2 overwrites them with the next window's sample 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data      <= '0;
            s1_valid     <= 1'b0;
            s1_restart   <= 1'b0;
            s1_mode      <= 1'b0;
            count        <= '0;
            pending      <= 1'b0;
            mode_q       <= 1'b0;
            s2_done      <= 1'b0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                acc[c] <= '0;
            end
            bus.dn_data  <= '0;
            bus.dn_valid <= 1'b0;
        end else begin
            s1_data    <= bus.up_data;
            s1_valid   <= bus.up_valid;
            s1_restart <= restart;
            s1_mode    <= cfg_mode;

            s2_done <= 1'b0;
            if (s1_valid) begin
                for (int c = 0; c < NUM_CHAN; c++) begin
                    acc[c] <= acc_next[c];
                end
                mode_q  <= eff_mode;
                count   <= last ? '0 : eff_count + CW'(1);
                pending <= 1'b0;
                s2_done <= last;
            end else if (s1_restart) begin
                count   <= '0;
                pending <= 1'b1;
            end

            bus.dn_valid <= s2_done;
            if (s2_done) begin
                bus.dn_data <= result;
            end
        end
    end
endmodule
